mips_multicycle_core: RTL and testbench

Multi-cycle MIPS-subset core that replaces the single-cycle datapath top. It keeps the single-cycle instruction subset and register/ALU semantics, but sequences each instruction through an explicit state machine. Instruction and data memories sit behind valid/acknowledge handshakes, so wait-state SRAMs or a bus bridge can be attached. The debug writeback port gains a valid strobe, and a retired-instruction counter is added.

---
 rtl/mips_multicycle_core_if.sv | 24 ++
 rtl/mips_multicycle_core.sv | 177 +++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_core_if.sv
// Instruction and data memory handshake bundle for the multi-cycle MIPS core.
// The core drives requests (master); memories or a bus bridge answer with acks (slave).
interface mips_multicycle_core_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;

    modport master (
        output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
        input  inst_ack, inst_rdata, data_ack, data_rdata
    );

    modport slave (
        input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata,
        output inst_ack, inst_rdata, data_ack, data_rdata
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: each instruction is stepped through BOOT/FETCH/DECODE/EXEC/MEM/WB
// with valid/ack memory handshakes, a committed-write debug port and a retired-instruction counter.
//
// state  | meaning
// BOOT   | reset state, one cycle before the first fetch
// FETCH  | inst_req high, wait for inst_ack, latch IR
// DECODE | read rs/rt into A/B, sign-extend imm, retire illegal opcodes
// EXEC   | ALU op; resolve beq/j
// MEM    | data_req high, wait for data_ack
// WB     | register-file write and debug commit
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_multicycle_core_if.master bus,
    output logic                 debug_wbvalid,
    output logic [31:0]          debug_wbdat,
    output logic [4:0]           debug_wbdst,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instret
);
    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW  = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25, FN_SLT = 6'h2A;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, ir, reg_a, reg_b, imm_sext, alu_out, mdr;
    logic [31:0] rf [0:31];
    logic [31:0] pc_plus4, br_target, j_target, operand_b, alu_result, wb_data;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wb_dst;
    logic        legal, retire;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                              (funct == FN_OR)  || (funct == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    assign operand_b = (op == OP_RTYPE) ? reg_b : imm_sext;

    always_comb begin
        alu_result = reg_a + operand_b;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_result = reg_a - reg_b;
                FN_AND:  alu_result = reg_a & reg_b;
                FN_OR:   alu_result = reg_a | reg_b;
                FN_SLT:  alu_result = {31'd0, $signed(reg_a) < $signed(reg_b)};
                default: alu_result = reg_a + reg_b;
            endcase
        end
    end

    // PC still holds the address of the executing instruction until it retires.
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign wb_dst    = (op == OP_RTYPE) ? rd : rt;
    assign wb_data   = (op == OP_LW) ? mdr : alu_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            S_BOOT:   state_next = S_FETCH;
            S_FETCH:  if (bus.inst_ack) state_next = S_DECODE;
            S_DECODE: begin
                if (legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_FETCH;
                    pc_next    = pc_plus4;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_BEQ: begin
                        state_next = S_FETCH;
                        pc_next    = (reg_a == reg_b) ? br_target : pc_plus4;
                    end
                    OP_J: begin
                        state_next = S_FETCH;
                        pc_next    = j_target;
                    end
                    OP_LW, OP_SW: state_next = S_MEM;
                    default:      state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.data_ack) begin
                    if (op == OP_SW) begin
                        state_next = S_FETCH;
                        pc_next    = pc_plus4;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                pc_next    = pc_plus4;
            end
            default: state_next = S_BOOT;
        endcase
    end

    assign retire = (state_next == S_FETCH) && (state != S_BOOT) && (state != S_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            ir            <= '0;
            reg_a         <= '0;
            reg_b         <= '0;
            imm_sext      <= '0;
            alu_out       <= '0;
            mdr           <= '0;
            debug_wbvalid <= 1'b0;
            debug_wbdat   <= '0;
            debug_wbdst   <= '0;
            instret       <= '0;
        end else begin
            pc            <= pc_next;
            debug_wbvalid <= (state == S_WB);
            if (retire) instret <= instret + CNT_W'(1);
            case (state)
                S_FETCH:  if (bus.inst_ack) ir <= bus.inst_rdata;
                S_DECODE: begin
                    reg_a    <= (rs == 5'd0) ? 32'd0 : rf[rs];
                    reg_b    <= (rt == 5'd0) ? 32'd0 : rf[rt];
                    imm_sext <= {{16{ir[15]}}, ir[15:0]};
                end
                S_EXEC:   alu_out <= alu_result;
                S_MEM:    if (bus.data_ack && (op == OP_LW)) mdr <= bus.data_rdata;
                S_WB: begin
                    debug_wbdat <= wb_data;
                    debug_wbdst <= wb_dst;
                end
                default: ;
            endcase
        end
    end

    // Register file is deliberately left unreset; $0 is forced to zero on read.
    always_ff @(posedge clk) begin
        if ((state == S_WB) && (wb_dst != 5'd0)) rf[wb_dst] <= wb_data;
    end

    assign illegal        = (state == S_DECODE) && !legal;
    assign bus.inst_req   = (state == S_FETCH);
    assign bus.inst_addr  = pc;
    assign bus.data_req   = (state == S_MEM);
    assign bus.data_wen   = (state == S_MEM) && (op == OP_SW);
    assign bus.data_addr  = alu_out;
    assign bus.data_wdata = reg_b;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: memory models with programmable wait states,
// a fetch/commit monitor, and one task per scenario with hand-computed expectations.
module tb_mips_multicycle_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       debug_wbvalid, illegal;
    logic [31:0] debug_wbdat;
    logic [4:0] debug_wbdst;
    logic [7:0] instret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_core_if bus();

    mips_multicycle_core #(.RESET_PC(32'h0000_0100), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .debug_wbvalid(debug_wbvalid), .debug_wbdat(debug_wbdat), .debug_wbdst(debug_wbdst),
        .illegal(illegal), .instret(instret)
    );

    localparam logic [31:0] LOOP_INSN = 32'h1000_FFFF;  // beq $0,$0,-1
    localparam logic [31:0] ILL_INSN  = 32'hFC00_0000;  // opcode 0x3F

    logic [31:0] imem [0:1023];
    logic [31:0] dmem [0:15];
    logic        inst_tie = 1'b0;
    int          inst_wait = 0, data_wait = 0;
    int          icnt = 0, dcnt = 0, cyc = 0;

    assign bus.inst_ack   = inst_tie | (bus.inst_req && (icnt == inst_wait));
    assign bus.inst_rdata = imem[bus.inst_addr[11:2]];
    assign bus.data_ack   = bus.data_req && (dcnt == data_wait);
    assign bus.data_rdata = dmem[bus.data_addr[5:2]];

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        icnt <= (bus.inst_req && !bus.inst_ack) ? icnt + 1 : 0;
        dcnt <= (bus.data_req && !bus.data_ack) ? dcnt + 1 : 0;
        if (bus.data_req && bus.data_ack && bus.data_wen) dmem[bus.data_addr[5:2]] <= bus.data_wdata;
    end

    logic [31:0] f_addr [$];
    int          f_cyc [$];
    logic [7:0]  f_ret [$];
    logic [4:0]  wb_dst [$];
    logic [31:0] wb_dat [$];
    int          ill_cnt = 0, stab_err = 0;
    logic        req_d = 1'b0, dreq_d = 1'b0, dack_d = 1'b0, pwen = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;

    always @(negedge clk) begin
        if (bus.inst_req && !req_d) begin
            f_addr.push_back(bus.inst_addr);
            f_cyc.push_back(cyc);
            f_ret.push_back(instret);
        end
        if (debug_wbvalid) begin
            wb_dst.push_back(debug_wbdst);
            wb_dat.push_back(debug_wbdat);
        end
        if (illegal) ill_cnt <= ill_cnt + 1;
        if (bus.data_req && dreq_d && !dack_d &&
            ((bus.data_addr != paddr) || (bus.data_wdata != pwdata) || (bus.data_wen != pwen)))
            stab_err <= stab_err + 1;
        req_d  <= bus.inst_req;
        dreq_d <= bus.data_req;
        dack_d <= bus.data_ack;
        paddr  <= bus.data_addr;
        pwdata <= bus.data_wdata;
        pwen   <= bus.data_wen;
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] index);
        return {6'h02, index};
    endfunction

    task automatic fill_default();
        for (int i = 0; i < 1024; i++) imem[i] = LOOP_INSN;
    endtask

    int rel_cyc = 0;

    task automatic hold_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        f_addr.delete(); f_cyc.delete(); f_ret.delete();
        wb_dst.delete(); wb_dat.delete();
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_fetches(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (f_addr.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        fill_default();
        imem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        inst_tie = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL reset_inst_req: got %b expected 0", bus.inst_req); end
        checks++; if (bus.data_req !== 1'b0 || bus.data_wen !== 1'b0) begin errors++; $display("FAIL reset_data_req_wen: got %b%b expected 00", bus.data_req, bus.data_wen); end
        checks++; if (debug_wbvalid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_pulses: got wbvalid=%b illegal=%b expected 0 0", debug_wbvalid, illegal); end
        checks++; if (debug_wbdat !== 32'd0 || debug_wbdst !== 5'd0) begin errors++; $display("FAIL reset_debug: got %h/%0d expected 0/0", debug_wbdat, debug_wbdst); end
        checks++; if (instret !== 8'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        checks++; if (bus.inst_addr !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected 00000100", bus.inst_addr); end
        hold_reset();
        wait_fetches(2, 30, ok);
        inst_tie = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL boot_timeout: fetches=%0d expected 2", f_addr.size()); return; end
        if (f_addr[0] !== 32'h100 || f_cyc[0] != rel_cyc + 1) begin
            errors++; $display("FAIL boot_first_fetch: got addr %h cycle +%0d expected 00000100 +1", f_addr[0], f_cyc[0] - rel_cyc);
        end
        checks++;
        if (f_addr[1] !== 32'h104 || f_cyc[1] - f_cyc[0] != 4) begin
            errors++; $display("FAIL boot_second_fetch: got addr %h after %0d expected 00000104 after 4", f_addr[1], f_cyc[1] - f_cyc[0]);
        end
    endtask

    task automatic test_alu_chain();
        bit ok;
        logic [4:0]  exp_d [8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
        logic [31:0] exp_v [8] = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd0};
        fill_default();
        imem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        imem[66] = enc_r(5'd3, 5'd1, 5'd2, 6'h20);
        imem[67] = enc_r(5'd4, 5'd2, 5'd1, 6'h2A);
        imem[68] = enc_r(5'd5, 5'd1, 5'd2, 6'h22);
        imem[69] = enc_r(5'd6, 5'd1, 5'd2, 6'h24);
        imem[70] = enc_r(5'd7, 5'd1, 5'd2, 6'h25);
        imem[71] = enc_r(5'd8, 5'd1, 5'd2, 6'h2A);
        hold_reset();
        wait_fetches(9, 100, ok);
        checks++;
        if (!ok || wb_dst.size() != 8) begin errors++; $display("FAIL alu_commit_count: got %0d expected 8", wb_dst.size()); return; end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (wb_dst[i] !== exp_d[i] || wb_dat[i] !== exp_v[i]) begin
                errors++; $display("FAIL alu_commit_%0d: got ($%0d,%h) expected ($%0d,%h)", i, wb_dst[i], wb_dat[i], exp_d[i], exp_v[i]);
            end
            checks++;
            if (f_cyc[i+1] - f_cyc[i] != 4) begin
                errors++; $display("FAIL alu_latency_%0d: got %0d expected 4", i, f_cyc[i+1] - f_cyc[i]);
            end
        end
        checks++; if (f_ret[8] !== 8'd8) begin errors++; $display("FAIL alu_instret: got %0d expected 8", f_ret[8]); end
    endtask

    task automatic test_mem_wait();
        bit ok;
        int stab0;
        fill_default();
        imem[64] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        imem[65] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
        data_wait = 3;
        stab0 = stab_err;
        hold_reset();
        wait_fetches(3, 100, ok);
        data_wait = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL mem_timeout: fetches=%0d expected 3", f_addr.size()); return; end
        checks++; if (f_cyc[1] - f_cyc[0] != 7) begin errors++; $display("FAIL mem_store_latency: got %0d expected 7", f_cyc[1] - f_cyc[0]); end
        checks++; if (f_cyc[2] - f_cyc[1] != 8) begin errors++; $display("FAIL mem_load_latency: got %0d expected 8", f_cyc[2] - f_cyc[1]); end
        checks++; if (dmem[2] !== 32'd2) begin errors++; $display("FAIL mem_store_data: got %h expected 00000002", dmem[2]); end
        checks++; if (stab_err != stab0) begin errors++; $display("FAIL mem_stability: got %0d changes expected 0", stab_err - stab0); end
        checks++;
        if (wb_dst.size() != 1 || wb_dst[0] !== 5'd5 || wb_dat[0] !== 32'd2) begin
            errors++; $display("FAIL mem_load_commit: got %0d commits first ($%0d,%h) expected 1 ($5,00000002)", wb_dst.size(), wb_dst[0], wb_dat[0]);
        end
        checks++; if (f_ret[2] !== 8'd2) begin errors++; $display("FAIL mem_instret: got %0d expected 2", f_ret[2]); end
    endtask

    task automatic test_control();
        bit ok;
        logic [31:0] exp_a [6] = '{32'h100, 32'h104, 32'h20, 32'h20, 32'h24, 32'h100};
        fill_default();
        imem[64] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        imem[65] = enc_j(26'd8);
        imem[8]  = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        imem[9]  = enc_j(26'h40);
        hold_reset();
        wait_fetches(3, 50, ok);
        imem[8]  = enc_i(6'h04, 5'd0, 5'd1, 16'd0);
        if (ok) wait_fetches(6, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ctrl_timeout: fetches=%0d expected 6", f_addr.size()); return; end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (f_addr[i] !== exp_a[i]) begin errors++; $display("FAIL ctrl_addr_%0d: got %h expected %h", i, f_addr[i], exp_a[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (f_cyc[i+1] - f_cyc[i] != 3) begin errors++; $display("FAIL ctrl_latency_%0d: got %0d expected 3", i, f_cyc[i+1] - f_cyc[i]); end
        end
    endtask

    task automatic test_edge();
        bit ok;
        int ill0;
        fill_default();
        imem[64] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        imem[65] = enc_r(5'd10, 5'd0, 5'd0, 6'h20);
        imem[66] = ILL_INSN;
        inst_wait = 1;
        ill0 = ill_cnt;
        hold_reset();
        wait_fetches(4, 60, ok);
        inst_wait = 0;
        checks++;
        if (!ok || wb_dst.size() != 2) begin errors++; $display("FAIL edge_commit_count: got %0d expected 2", wb_dst.size()); return; end
        checks++; if (wb_dst[0] !== 5'd0 || wb_dat[0] !== 32'd7) begin errors++; $display("FAIL edge_r0_report: got ($%0d,%h) expected ($0,00000007)", wb_dst[0], wb_dat[0]); end
        checks++; if (wb_dst[1] !== 5'd10 || wb_dat[1] !== 32'd0) begin errors++; $display("FAIL edge_r0_reads_zero: got ($%0d,%h) expected ($10,00000000)", wb_dst[1], wb_dat[1]); end
        checks++; if (ill_cnt - ill0 != 1) begin errors++; $display("FAIL edge_illegal_pulses: got %0d expected 1", ill_cnt - ill0); end
        checks++; if (f_addr[3] !== 32'h10C) begin errors++; $display("FAIL edge_illegal_next_pc: got %h expected 0000010c", f_addr[3]); end
        checks++; if (f_cyc[1] - f_cyc[0] != 5) begin errors++; $display("FAIL edge_inst_wait_latency: got %0d expected 5", f_cyc[1] - f_cyc[0]); end
        checks++; if (f_cyc[3] - f_cyc[2] != 3) begin errors++; $display("FAIL edge_illegal_latency: got %0d expected 3", f_cyc[3] - f_cyc[2]); end
        checks++; if (f_ret[3] !== 8'd3) begin errors++; $display("FAIL edge_instret: got %0d expected 3", f_ret[3]); end
    endtask

    task automatic test_instret_wrap();
        bit ok;
        fill_default();
        for (int i = 64; i < 320; i++) imem[i] = ILL_INSN;
        hold_reset();
        wait_fetches(257, 700, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout: fetches=%0d expected 257", f_addr.size()); return; end
        checks++; if (f_ret[255] !== 8'd255) begin errors++; $display("FAIL wrap_before: got %0d expected 255", f_ret[255]); end
        checks++; if (f_ret[256] !== 8'd0 || f_addr[256] !== 32'h500) begin errors++; $display("FAIL wrap_after: got %0d at %h expected 0 at 00000500", f_ret[256], f_addr[256]); end
    endtask

    task automatic test_reset_mid_mem();
        bit ok;
        bit seen;
        fill_default();
        imem[64] = enc_i(6'h08, 5'd0, 5'd11, 16'h0055);
        imem[65] = enc_i(6'h23, 5'd0, 5'd11, 16'd8);
        data_wait = 20;
        hold_reset();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.data_req) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midrst_no_data_req: got 0 expected 1"); return; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL midrst_data_req_drop: got %b expected 0", bus.data_req); end
        checks++; if (instret !== 8'd0) begin errors++; $display("FAIL midrst_instret_clear: got %0d expected 0", instret); end
        checks++; if (wb_dst.size() != 1) begin errors++; $display("FAIL midrst_commits: got %0d expected 1", wb_dst.size()); end
        imem[64] = enc_r(5'd12, 5'd11, 5'd0, 6'h20);
        data_wait = 0;
        hold_reset();
        wait_fetches(2, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_timeout: fetches=%0d expected 2", f_addr.size()); return; end
        checks++; if (f_addr[0] !== 32'h100 || f_ret[0] !== 8'd0) begin errors++; $display("FAIL midrst_restart: got %h instret %0d expected 00000100 instret 0", f_addr[0], f_ret[0]); end
        checks++;
        if (wb_dst.size() != 1 || wb_dst[0] !== 5'd12 || wb_dat[0] !== 32'h55) begin
            errors++; $display("FAIL midrst_no_write: got %0d commits first ($%0d,%h) expected 1 ($12,00000055)", wb_dst.size(), wb_dst[0], wb_dat[0]);
        end
        checks++; if (f_ret[1] !== 8'd1) begin errors++; $display("FAIL midrst_instret_count: got %0d expected 1", f_ret[1]); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_alu_chain();
        test_mem_wait();
        test_control();
        test_edge();
        test_instret_wrap();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
